filter_edge_det_ctrl: RTL and testbench

//  Control/configuration block for the Sobel edge-detector stage.
//  - Holds a host-writable register bank and drives the detector's bypass, gate, threshold_h and threshold_l inputs.
//  - Applies new settings only at frame boundaries, so the detector never sees a mid-frame change.
//  - Optional auto-threshold mode: measures the mean edge magnitude of each output frame and derives the next frame's thresholds from it.
//  - Sits between the host register bus and the detector; monitors the detector's output stream.

---
 rtl/filter_edge_ctrl_pkg.sv | 24 ++
 rtl/seq_div_restoring.sv | 76 +++++++
 rtl/filter_edge_det_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_filter_edge_det_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_edge_ctrl_pkg.sv
// Shared definitions for the edge-detector control block: register map,
// CTRL bit positions and auto-threshold FSM states.
package filter_edge_ctrl_pkg;

   localparam logic [2:0] ADDR_CTRL      = 3'd0;
   localparam logic [2:0] ADDR_THR_H     = 3'd1;
   localparam logic [2:0] ADDR_THR_L     = 3'd2;
   localparam logic [2:0] ADDR_AUTO_OFS  = 3'd3;
   localparam logic [2:0] ADDR_MEAN      = 3'd4;
   localparam logic [2:0] ADDR_FRAME_CNT = 3'd5;

   localparam int CTRL_BYPASS  = 0;
   localparam int CTRL_GATE    = 1;
   localparam int CTRL_AUTO_EN = 2;
   localparam int CTRL_APPLY   = 3;
   localparam int CTRL_OVR     = 4;

   typedef enum logic [1:0] {
      ST_ACC = 2'd0,
      ST_DIV = 2'd1,
      ST_UPD = 2'd2
   } fsm_state_e;

endpackage

// File: rtl/seq_div_restoring.sv
// Restoring divider, one quotient bit per cycle; quot valid on the done pulse,
// N_WIDTH cycles after start. start restarts even while busy; abort drops the job.
module seq_div_restoring #(
   parameter int N_WIDTH = 30,
   parameter int D_WIDTH = 22
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [N_WIDTH-1:0] num,
   input  logic [D_WIDTH-1:0] den,
   output logic               busy,
   output logic               done,
   output logic [N_WIDTH-1:0] quot
);

   localparam int CW = $clog2(N_WIDTH + 1);

   logic [N_WIDTH-1:0] num_q;
   logic [N_WIDTH-1:0] quot_q;
   logic [D_WIDTH-1:0] den_q;
   logic [D_WIDTH-1:0] rem_q;
   logic [CW-1:0]      cnt_q;
   logic               busy_q;
   logic               done_q;

   logic [D_WIDTH:0]   rem_sh;
   logic [D_WIDTH-1:0] diff;
   logic               q_bit;

   // The remainder is always below den, so the subtraction fits in D_WIDTH bits.
   always_comb begin
      rem_sh = {rem_q, num_q[N_WIDTH-1]};
      q_bit  = (rem_sh >= {1'b0, den_q});
      diff   = rem_sh[D_WIDTH-1:0] - den_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         num_q  <= '0;
         quot_q <= '0;
         den_q  <= '0;
         rem_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            num_q  <= num;
            den_q  <= den;
            rem_q  <= '0;
            quot_q <= '0;
            cnt_q  <= CW'(N_WIDTH);
            busy_q <= 1'b1;
         end else if (abort) begin
            busy_q <= 1'b0;
         end else if (busy_q) begin
            num_q  <= {num_q[N_WIDTH-2:0], 1'b0};
            rem_q  <= q_bit ? diff : rem_sh[D_WIDTH-1:0];
            quot_q <= {quot_q[N_WIDTH-2:0], q_bit};
            cnt_q  <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign quot = quot_q;

endmodule

// File: rtl/filter_edge_det_ctrl.sv
// Register bank and frame-synchronous settings for the Sobel detector, with optional auto-threshold.
// Register access acks one cycle after the strobe; settings land one cycle after the vsync rising edge.
module filter_edge_det_ctrl #(
   parameter int DATA_WIDTH    = 8,
   parameter int PIX_CNT_WIDTH = 22,
   parameter int SUM_WIDTH     = 30
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  reg_wr,
   input  logic                  reg_rd,
   input  logic [2:0]            reg_addr,
   input  logic [15:0]           reg_wdata,
   output logic [15:0]           reg_rdata,
   output logic                  reg_ack,
   input  logic [DATA_WIDTH-1:0] mon_do,
   input  logic                  mon_de,
   input  logic                  mon_vs,
   output logic                  bypass,
   output logic                  gate,
   output logic [15:0]           threshold_h,
   output logic [15:0]           threshold_l,
   output logic                  irq
);
   import filter_edge_ctrl_pkg::*;

   localparam int MAG_MAX = (1 << DATA_WIDTH) - 1;

   // Host-visible state
   logic                  bypass_sh_q, gate_sh_q, auto_en_q, apply_pend_q, ovr_q;
   logic [15:0]           thr_h_sh_q, thr_l_sh_q, auto_ofs_q, frame_cnt_q;
   logic [DATA_WIDTH-1:0] mean_q;
   logic [15:0]           reg_rdata_q, rd_mux;
   logic                  reg_ack_q;

   // Active detector settings
   logic                  bypass_q, gate_q, irq_q;
   logic [15:0]           thr_h_q, thr_l_q;

   // Frame statistics and FSM
   logic                  vs_d_q, vs_edge, wr_ctrl;
   logic [SUM_WIDTH-1:0]     sum_q, sum_d;
   logic [PIX_CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                  sat_hit;
   fsm_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] res_q, res_d;
   logic                  div_start, div_abort, div_busy, div_done, fsm_ovr;
   logic [SUM_WIDTH-1:0]  div_quot;
   logic [16:0]           thr_sum;
   logic [15:0]           thr_h_auto;

   assign vs_edge = mon_vs & ~vs_d_q;
   assign wr_ctrl = reg_wr && (reg_addr == ADDR_CTRL);

   always_comb begin
      rd_mux = '0;
      case (reg_addr)
         ADDR_CTRL:      rd_mux = {11'd0, ovr_q, apply_pend_q, auto_en_q, gate_sh_q, bypass_sh_q};
         ADDR_THR_H:     rd_mux = thr_h_sh_q;
         ADDR_THR_L:     rd_mux = thr_l_sh_q;
         ADDR_AUTO_OFS:  rd_mux = auto_ofs_q;
         ADDR_MEAN:      rd_mux = 16'(mean_q);
         ADDR_FRAME_CNT: rd_mux = frame_cnt_q;
         default:        rd_mux = '0;
      endcase
   end

   // Accumulation stops once the pixel count saturates so the sum cannot wrap.
   always_comb begin
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      sat_hit = 1'b0;
      if (vs_edge) begin
         sum_d = '0;
         cnt_d = '0;
      end else if (mon_de) begin
         if (cnt_q == {PIX_CNT_WIDTH{1'b1}}) begin
            sat_hit = 1'b1;
         end else begin
            sum_d = sum_q + SUM_WIDTH'(mon_do);
            cnt_d = cnt_q + PIX_CNT_WIDTH'(1);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      res_d     = res_q;
      div_start = 1'b0;
      div_abort = 1'b0;
      fsm_ovr   = 1'b0;
      case (state_q)
         ST_DIV: begin
            if (vs_edge) begin
               div_abort = div_busy;
               fsm_ovr   = 1'b1;
               state_d   = ST_ACC;
            end else if (div_done) begin
               res_d   = (div_quot > SUM_WIDTH'(MAG_MAX)) ? DATA_WIDTH'(MAG_MAX)
                                                          : div_quot[DATA_WIDTH-1:0];
               state_d = ST_UPD;
            end
         end
         ST_UPD:  state_d = ST_ACC;
         default: state_d = ST_ACC;
      endcase
      // A new frame boundary always launches its own measurement, even mid-divide.
      if (vs_edge && auto_en_q) begin
         if (cnt_q == '0) begin
            res_d   = '0;
            state_d = ST_UPD;
         end else begin
            div_start = 1'b1;
            state_d   = ST_DIV;
         end
      end
   end

   always_comb begin
      thr_sum    = 17'(res_q) + 17'(auto_ofs_q);
      thr_h_auto = (thr_sum > 17'(MAG_MAX)) ? 16'(MAG_MAX) : thr_sum[15:0];
   end

   seq_div_restoring #(
      .N_WIDTH(SUM_WIDTH),
      .D_WIDTH(PIX_CNT_WIDTH)
   ) u_div (
      .clk  (clk),
      .rst  (rst),
      .start(div_start),
      .abort(div_abort),
      .num  (sum_q),
      .den  (cnt_q),
      .busy (div_busy),
      .done (div_done),
      .quot (div_quot)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         bypass_sh_q  <= 1'b0;
         gate_sh_q    <= 1'b0;
         auto_en_q    <= 1'b0;
         apply_pend_q <= 1'b0;
         ovr_q        <= 1'b0;
         thr_h_sh_q   <= '0;
         thr_l_sh_q   <= '0;
         auto_ofs_q   <= '0;
         frame_cnt_q  <= '0;
         reg_ack_q    <= 1'b0;
         reg_rdata_q  <= '0;
         vs_d_q       <= 1'b0;
      end else begin
         vs_d_q      <= mon_vs;
         reg_ack_q   <= reg_wr | reg_rd;
         reg_rdata_q <= (reg_rd && !reg_wr) ? rd_mux : '0;
         if (vs_edge) frame_cnt_q <= frame_cnt_q + 16'd1;
         if (reg_wr) begin
            case (reg_addr)
               ADDR_CTRL: begin
                  bypass_sh_q <= reg_wdata[CTRL_BYPASS];
                  gate_sh_q   <= reg_wdata[CTRL_GATE];
                  auto_en_q   <= reg_wdata[CTRL_AUTO_EN];
               end
               ADDR_THR_H:    thr_h_sh_q <= reg_wdata;
               ADDR_THR_L:    thr_l_sh_q <= reg_wdata;
               ADDR_AUTO_OFS: auto_ofs_q <= reg_wdata;
               default: ;
            endcase
         end
         if (wr_ctrl && reg_wdata[CTRL_APPLY]) apply_pend_q <= 1'b1;
         else if (vs_edge)                     apply_pend_q <= 1'b0;
         if (fsm_ovr || sat_hit)               ovr_q <= 1'b1;
         else if (wr_ctrl && reg_wdata[CTRL_OVR]) ovr_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_ACC;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
      end
   end

   // Shadow values are sampled before this cycle's write lands, so a write on the edge waits a frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         bypass_q <= 1'b0;
         gate_q   <= 1'b0;
         thr_h_q  <= '0;
         thr_l_q  <= '0;
         mean_q   <= '0;
         irq_q    <= 1'b0;
      end else begin
         irq_q <= 1'b0;
         if (vs_edge && apply_pend_q) begin
            bypass_q <= bypass_sh_q;
            gate_q   <= gate_sh_q;
            irq_q    <= 1'b1;
            if (!auto_en_q) begin
               thr_h_q <= thr_h_sh_q;
               thr_l_q <= thr_l_sh_q;
            end
         end
         if (state_q == ST_UPD) begin
            mean_q  <= res_q;
            thr_l_q <= 16'(res_q);
            thr_h_q <= thr_h_auto;
         end
      end
   end

   assign reg_rdata   = reg_rdata_q;
   assign reg_ack     = reg_ack_q;
   assign bypass      = bypass_q;
   assign gate        = gate_q;
   assign threshold_h = thr_h_q;
   assign threshold_l = thr_l_q;
   assign irq         = irq_q;

endmodule

// File: tb/tb_filter_edge_det_ctrl.sv
// Scoreboard bench: register reads and applied settings are queued at issue time
// and compared by a monitor when reg_ack / irq appear; auto thresholds use a plain mean model.
module tb_filter_edge_det_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        reg_wr, reg_rd;
   logic [2:0]  reg_addr;
   logic [15:0] reg_wdata, reg_rdata;
   logic        reg_ack;
   logic [7:0]  mon_do;
   logic        mon_de, mon_vs;
   logic        bypass, gate, irq;
   logic [15:0] threshold_h, threshold_l;

   always #5 clk = ~clk;

   filter_edge_det_ctrl dut (
      .clk(clk), .rst(rst),
      .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
      .mon_do(mon_do), .mon_de(mon_de), .mon_vs(mon_vs),
      .bypass(bypass), .gate(gate),
      .threshold_h(threshold_h), .threshold_l(threshold_l), .irq(irq)
   );

   typedef struct { bit is_rd; logic [2:0] addr; logic [15:0] exp; } rq_t;
   typedef struct { logic byp; logic gt; logic [15:0] th; logic [15:0] tl; } oq_t;

   rq_t rq[$];
   oq_t oq[$];
   rq_t mon_r;
   oq_t mon_o;

   int total = 0;
   int bad   = 0;

   // reference state
   logic        m_byp, m_gate;
   logic [15:0] m_th, m_tl;
   int          exp_frames = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (reg_ack) begin
            if (rq.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_ack: got ack with no access outstanding");
            end else begin
               mon_r = rq.pop_front();
               if (mon_r.is_rd) chk($sformatf("read_addr%0d", mon_r.addr), reg_rdata, mon_r.exp);
            end
         end
         if (irq) begin
            if (oq.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_irq: irq pulsed with no apply expected");
            end else begin
               mon_o = oq.pop_front();
               chk("irq_bypass", bypass, mon_o.byp);
               chk("irq_gate",   gate,   mon_o.gt);
               chk("irq_thr_h",  threshold_h, mon_o.th);
               chk("irq_thr_l",  threshold_l, mon_o.tl);
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
      rq.push_back('{1'b0, a, 16'h0});
      tick();
      reg_wr = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [15:0] e);
      reg_rd = 1'b1; reg_addr = a;
      rq.push_back('{1'b1, a, e});
      tick();
      reg_rd = 1'b0;
   endtask

   task automatic vs_pulse();
      mon_vs = 1'b1;
      tick();
      mon_vs = 1'b0;
      exp_frames++;
   endtask

   // Sends n pixels (val<0 means random) and returns their arithmetic sum.
   task automatic pixels(input int n, input int val, output int sum);
      sum = 0;
      for (int i = 0; i < n; i++) begin
         mon_de = 1'b1;
         mon_do = (val < 0) ? 8'($urandom_range(0, 255)) : 8'(val);
         sum += int'(mon_do);
         tick();
      end
      mon_de = 1'b0;
      tick();
   endtask

   task automatic check_out(input string nm);
      chk({nm, "_bypass"}, bypass, m_byp);
      chk({nm, "_gate"},   gate,   m_gate);
      chk({nm, "_thr_h"},  threshold_h, m_th);
      chk({nm, "_thr_l"},  threshold_l, m_tl);
   endtask

   // Auto mode: thresholds follow floor(mean) of the frame just ended.
   task automatic auto_model(input int sum, input int n, input int ofs);
      int mean;
      mean = (n == 0) ? 0 : sum / n;
      if (mean > 255) mean = 255;
      m_tl = 16'(mean);
      m_th = 16'((mean + ofs > 255) ? 255 : mean + ofs);
   endtask

   initial begin
      int s, n, ofs;
      rst = 1'b1; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0;
      mon_do = '0; mon_de = 1'b0; mon_vs = 1'b0;
      m_byp = 1'b0; m_gate = 1'b0; m_th = '0; m_tl = '0;
      idle(3);
      rst = 1'b0;
      tick();

      // T1: reset state
      check_out("reset");
      chk("reset_irq", irq, 1'b0);
      for (int a = 0; a < 8; a++) rd(3'(a), 16'h0);

      // T2: staged settings only take effect at the frame boundary
      wr(3'd1, 16'd200);
      wr(3'd2, 16'd20);
      wr(3'd0, 16'h000B);
      idle(3);
      check_out("t2_staged");
      rd(3'd0, 16'h000B);
      oq.push_back('{1'b1, 1'b1, 16'd200, 16'd20});
      vs_pulse();
      m_byp = 1'b1; m_gate = 1'b1; m_th = 16'd200; m_tl = 16'd20;
      check_out("t2_applied");
      rd(3'd0, 16'h0003);
      rd(3'd5, 16'(exp_frames));

      // T3: apply written on the edge cycle waits for the next frame
      wr(3'd1, 16'd100);
      wr(3'd0, 16'h0003);
      mon_vs = 1'b1; reg_wr = 1'b1; reg_addr = 3'd0; reg_wdata = 16'h0008;
      rq.push_back('{1'b0, 3'd0, 16'h0});
      tick();
      mon_vs = 1'b0; reg_wr = 1'b0; exp_frames++;
      idle(2);
      check_out("t3_hold");
      rd(3'd0, 16'h0008);
      oq.push_back('{1'b0, 1'b0, 16'd100, 16'd20});
      vs_pulse();
      m_byp = 1'b0; m_gate = 1'b0; m_th = 16'd100;
      check_out("t3_applied");
      rd(3'd0, 16'h0000);

      // pending apply uses shadow values from before a same-cycle write
      wr(3'd0, 16'h000B);
      oq.push_back('{1'b1, 1'b1, 16'd100, 16'd20});
      mon_vs = 1'b1; reg_wr = 1'b1; reg_addr = 3'd1; reg_wdata = 16'd55;
      rq.push_back('{1'b0, 3'd1, 16'h0});
      tick();
      mon_vs = 1'b0; reg_wr = 1'b0; exp_frames++;
      m_byp = 1'b1; m_gate = 1'b1;
      check_out("edge_write");
      rd(3'd1, 16'd55);

      // simultaneous write and read: one ack, write performed
      reg_wr = 1'b1; reg_rd = 1'b1; reg_addr = 3'd2; reg_wdata = 16'd33;
      rq.push_back('{1'b0, 3'd2, 16'h0});
      tick();
      reg_wr = 1'b0; reg_rd = 1'b0;
      rd(3'd2, 16'd33);
      wr(3'd6, 16'hFFFF);
      rd(3'd6, 16'h0);
      rd(3'd7, 16'h0);

      // T4: auto threshold from a uniform frame
      wr(3'd3, 16'd30);
      wr(3'd0, 16'h0004);
      pixels(100, 40, s);
      vs_pulse();
      idle(40);
      auto_model(s, 100, 30);
      check_out("t4_auto");
      rd(3'd4, 16'd40);

      // randomized frames
      for (int f = 0; f < 6; f++) begin
         ofs = $urandom_range(0, 300);
         wr(3'd3, 16'(ofs));
         n = $urandom_range(1, 60);
         pixels(n, -1, s);
         vs_pulse();
         idle(40);
         auto_model(s, n, ofs);
         check_out($sformatf("rand%0d", f));
         rd(3'd4, m_tl);
      end

      // T5: threshold_h clamp, then an empty frame
      wr(3'd3, 16'd250);
      pixels(10, 250, s);
      vs_pulse();
      idle(40);
      auto_model(s, 10, 250);
      check_out("t5_clamp");
      vs_pulse();
      idle(40);
      auto_model(0, 0, 250);
      check_out("t5_empty");
      rd(3'd4, 16'd0);

      // T6: short vblank aborts the divide and flags overrun
      rd(3'd0, 16'h0004);
      pixels(20, 100, s);
      vs_pulse();
      idle(5);
      pixels(20, 60, s);
      vs_pulse();
      check_out("t6_aborted");
      rd(3'd0, 16'h0014);
      idle(40);
      auto_model(s, 20, 250);
      check_out("t6_next");
      rd(3'd4, 16'd60);
      wr(3'd0, 16'h0014);
      rd(3'd0, 16'h0004);
      rd(3'd5, 16'(exp_frames));

      idle(5);
      chk("reads_outstanding", rq.size(), 0);
      chk("irqs_outstanding",  oq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
